// File: rtl/hub75e_pkg.sv
// Shared types, sizes and pixel conversion for the HUB75E frame-buffer path.
package hub75e_pkg;

  localparam int unsigned COL_BITS = 6;
  localparam int unsigned ROW_BITS = 5;
  localparam int unsigned PWM_BITS = 5;
  localparam int unsigned ADDR_W   = ROW_BITS + COL_BITS;
  localparam int unsigned Y_BITS   = ROW_BITS + 1;
  localparam int unsigned PIX_W    = 16;
  localparam int unsigned WORD_W   = 2 * PIX_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    PEND = 2'd2
  } state_e;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb888_t;

  // Truncating RGB888 -> RGB555, MSB of the 16-bit pixel is always zero.
  function automatic logic [PIX_W-1:0] rgb555(input rgb888_t px);
    return {1'b0, px.r[7 -: PWM_BITS], px.g[7 -: PWM_BITS], px.b[7 -: PWM_BITS]};
  endfunction

endpackage

// File: rtl/hub75e_pixram.sv
// Double-bank pixel RAM: one write port with per-lane enables, one registered read port.
module hub75e_pixram
  import hub75e_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          we,
  input  logic [ADDR_W:0]     waddr,
  input  logic [WORD_W-1:0]   wdata,
  input  logic [ADDR_W:0]     raddr,
  output logic [WORD_W-1:0]   rdata
);

  localparam int unsigned DEPTH = 1 << (ADDR_W + 1);

  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [WORD_W-1:0] rdata_q;

  // Lane-masked write; upper lane holds row y, lower lane holds row y+32.
  always_ff @(posedge clk) begin
    if (we[1]) mem_q[waddr][WORD_W-1:PIX_W] <= wdata[WORD_W-1:PIX_W];
    if (we[0]) mem_q[waddr][PIX_W-1:0]      <= wdata[PIX_W-1:0];
  end

  // Registered read data, cleared on reset (array contents are not).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rdata_q <= '0;
    else       rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/hub75e_fb_loader.sv
// Loads an RGB888 raster stream into the write bank of a double-buffered
// RGB555 pixel RAM and swaps banks on scanner frame end once a frame is complete.
module hub75e_fb_loader
  import hub75e_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic                s_sof,
  input  logic [23:0]         s_data,
  input  logic                scan_frame_done,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic [WORD_W-1:0]   rd_data,
  output logic                disp_bank,
  output logic                frame_err
);

  state_e              state_q, state_d;
  logic [COL_BITS-1:0] x_q, x_d;
  logic [Y_BITS-1:0]   y_q, y_d;
  logic                bank_q, bank_d;
  logic                err_q, err_d;
  logic                ready_q, ready_d;

  logic                xfer;
  logic                wr_en;
  logic [COL_BITS-1:0] wr_x;
  logic [Y_BITS-1:0]   wr_y;
  logic [PIX_W-1:0]    pix;
  logic [1:0]          ram_we;
  logic [ADDR_W:0]     ram_waddr;
  logic [ADDR_W:0]     ram_raddr;

  assign xfer = s_valid & ready_q;
  assign pix  = rgb555(rgb888_t'(s_data));

  // Next state, raster counters, bank swap and write command.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    bank_d  = bank_q;
    err_d   = 1'b0;
    wr_en   = 1'b0;
    wr_x    = x_q;
    wr_y    = y_q;
    case (state_q)
      IDLE: begin
        if (xfer && s_sof) begin
          wr_en   = 1'b1;
          wr_x    = '0;
          wr_y    = '0;
          x_d     = COL_BITS'(1);
          y_d     = '0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (xfer) begin
          wr_en = 1'b1;
          if (s_sof) begin
            err_d = 1'b1;
            wr_x  = '0;
            wr_y  = '0;
            x_d   = COL_BITS'(1);
            y_d   = '0;
          end else if (x_q == '1) begin
            x_d = '0;
            if (y_q == '1) begin
              y_d     = '0;
              state_d = PEND;
            end else begin
              y_d = y_q + Y_BITS'(1);
            end
          end else begin
            x_d = x_q + COL_BITS'(1);
          end
        end
      end
      PEND: begin
        if (scan_frame_done) begin
          bank_d  = ~bank_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d != PEND);
  end

  // State and counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      bank_q  <= 1'b0;
      err_q   <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      bank_q  <= bank_d;
      err_q   <= err_d;
      ready_q <= ready_d;
    end
  end

  assign ram_we    = wr_en ? (wr_y[Y_BITS-1] ? 2'b01 : 2'b10) : 2'b00;
  assign ram_waddr = {~bank_q, wr_y[ROW_BITS-1:0], wr_x};
  assign ram_raddr = {bank_q, rd_addr};

  hub75e_pixram u_pixram (
    .clk   (clk),
    .reset (reset),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata ({pix, pix}),
    .raddr (ram_raddr),
    .rdata (rd_data)
  );

  assign s_ready   = ready_q;
  assign disp_bank = bank_q;
  assign frame_err = err_q;

endmodule

// File: tb/tb_hub75e_fb_loader.sv
// Self-checking bench for hub75e_fb_loader: frame loads, bank swaps, restart and reset cases.
module tb_hub75e_fb_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        s_valid;
  logic        s_ready;
  logic        s_sof;
  logic [23:0] s_data;
  logic        scan_frame_done;
  logic [10:0] rd_addr;
  logic [31:0] rd_data;
  logic        disp_bank;
  logic        frame_err;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [10:0] addr;
    logic [31:0] exp;
  } vec_t;

  vec_t        tbl [8];
  int          tr  [8] = '{3, 0, 0, 0, 31, 15, 31, 17};
  int          tc  [8] = '{7, 0, 1, 4, 63, 32, 0, 45};
  logic [31:0] sb  [$];

  hub75e_fb_loader dut (
    .clk             (clk),
    .reset           (reset),
    .s_valid         (s_valid),
    .s_ready         (s_ready),
    .s_sof           (s_sof),
    .s_data          (s_data),
    .scan_frame_done (scan_frame_done),
    .rd_addr         (rd_addr),
    .rd_data         (rd_data),
    .disp_bank       (disp_bank),
    .frame_err       (frame_err)
  );

  always #5 clk = ~clk;

  // Input pixel patterns, indexed by pattern number.
  function automatic logic [23:0] pix(input int p, input int x, input int y);
    logic [7:0] xb, yb;
    xb = 8'(x);
    yb = 8'(y);
    case (p)
      0:       return {xb, yb, 8'h5A};
      1:       return {xb << 2, yb << 2, 8'hA5};
      2:       return {~(xb << 2), (yb << 2) ^ 8'h3C, 8'(x * 3 + y)};
      default: return {yb << 2, 8'hF0 - (xb << 1), xb << 2};
    endcase
  endfunction

  function automatic logic [15:0] m555(input logic [23:0] d);
    return {1'b0, d[23:19], d[15:11], d[7:3]};
  endfunction

  function automatic logic [31:0] exp_word(input int p, input int row, input int col);
    return {m555(pix(p, col, row)), m555(pix(p, col, row + 32))};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Stream raster pixels first..first+count-1 of pattern p; sfd_a/sfd_b raise scan_frame_done.
  task automatic stream(input int p, input int first, input int count, input bit sof_first,
                        input int sfd_a, input int sfd_b);
    bit rdy_ok = 1'b1;
    for (int k = first; k < first + count; k++) begin
      if (s_ready !== 1'b1) rdy_ok = 1'b0;
      s_valid         = 1'b1;
      s_data          = pix(p, k % 64, k / 64);
      s_sof           = sof_first && (k == first);
      scan_frame_done = (k == sfd_a) || (k == sfd_b);
      step();
    end
    s_valid         = 1'b0;
    s_sof           = 1'b0;
    scan_frame_done = 1'b0;
    chk("stream_ready", 32'(rdy_ok), 32'd1);
  endtask

  task automatic pulse_sfd();
    scan_frame_done = 1'b1;
    step();
    scan_frame_done = 1'b0;
  endtask

  // Apply the address table, scoreboarding expected words for pattern p.
  task automatic read_table(input int p);
    for (int i = 0; i < 8; i++) tbl[i].exp = exp_word(p, tr[i], tc[i]);
    for (int i = 0; i < 8; i++) begin
      rd_addr = tbl[i].addr;
      sb.push_back(tbl[i].exp);
      step();
      chk("rd_data", rd_data, sb.pop_front());
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) tbl[i].addr = {5'(tr[i]), 6'(tc[i])};
    reset           = 1'b1;
    s_valid         = 1'b0;
    s_sof           = 1'b0;
    s_data          = '0;
    scan_frame_done = 1'b0;
    rd_addr         = '0;

    // Reset state
    #2;
    chk("rst_s_ready", 32'(s_ready), 32'd0);
    chk("rst_disp_bank", 32'(disp_bank), 32'd0);
    chk("rst_frame_err", 32'(frame_err), 32'd0);
    chk("rst_rd_data", rd_data, 32'd0);
    step();
    reset = 1'b0;
    step();
    chk("idle_s_ready", 32'(s_ready), 32'd1);

    // Full frame, swap, readback
    stream(0, 0, 4096, 1'b1, -1, -1);
    chk("t1_pend_ready", 32'(s_ready), 32'd0);
    chk("t1_no_err", 32'(frame_err), 32'd0);
    chk("t1_bank_hold", 32'(disp_bank), 32'd0);
    pulse_sfd();
    chk("t1_swap", 32'(disp_bank), 32'd1);
    chk("t1_ready", 32'(s_ready), 32'd1);
    read_table(0);

    // Frame held in PEND until scanner frame end
    stream(1, 0, 4096, 1'b1, -1, -1);
    repeat (100) step();
    chk("t2_pend_ready", 32'(s_ready), 32'd0);
    chk("t2_bank_hold", 32'(disp_bank), 32'd1);
    pulse_sfd();
    chk("t2_swap", 32'(disp_bank), 32'd0);
    chk("t2_ready", 32'(s_ready), 32'd1);
    read_table(1);

    // Mid-frame SOF restarts counters
    stream(2, 0, 1000, 1'b1, -1, -1);
    s_valid = 1'b1; s_sof = 1'b1; s_data = pix(3, 0, 0);
    step();
    chk("t3_err_pulse", 32'(frame_err), 32'd1);
    s_sof = 1'b0; s_data = pix(3, 1, 0);
    step();
    chk("t3_err_single", 32'(frame_err), 32'd0);
    stream(3, 2, 4094, 1'b0, -1, -1);
    chk("t3_pend_ready", 32'(s_ready), 32'd0);
    pulse_sfd();
    chk("t3_swap", 32'(disp_bank), 32'd1);
    read_table(3);

    // Pixels without SOF in IDLE are dropped
    for (int i = 0; i < 5; i++) begin
      s_valid = 1'b1; s_sof = 1'b0; s_data = 24'hFFFFFF;
      step();
    end
    s_valid = 1'b0;
    chk("t4_ready", 32'(s_ready), 32'd1);
    pulse_sfd();
    chk("t4_no_swap", 32'(disp_bank), 32'd1);
    s_valid = 1'b1; s_sof = 1'b1; s_data = pix(1, 0, 0);
    step();
    s_valid = 1'b0; s_sof = 1'b0;
    chk("t4_idle_sof_no_err", 32'(frame_err), 32'd0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    chk("t4_reset_bank", 32'(disp_bank), 32'd0);
    read_table(1);

    // scan_frame_done during LOAD and on the last transfer is ignored
    stream(0, 0, 4096, 1'b1, 500, 4095);
    chk("t5_no_swap", 32'(disp_bank), 32'd0);
    chk("t5_pend_ready", 32'(s_ready), 32'd0);
    repeat (3) step();
    chk("t5_still_pend", 32'(s_ready), 32'd0);
    pulse_sfd();
    chk("t5_swap", 32'(disp_bank), 32'd1);
    read_table(0);

    // Asynchronous reset mid-LOAD
    stream(1, 0, 1999, 1'b1, -1, -1);
    s_valid = 1'b1; s_sof = 1'b1; s_data = pix(1, 0, 0);
    step();
    s_valid = 1'b0; s_sof = 1'b0;
    chk("t6_err_before_rst", 32'(frame_err), 32'd1);
    #3 reset = 1'b1;
    #1;
    chk("t6_rst_ready", 32'(s_ready), 32'd0);
    chk("t6_rst_bank", 32'(disp_bank), 32'd0);
    chk("t6_rst_err", 32'(frame_err), 32'd0);
    chk("t6_rst_rd_data", rd_data, 32'd0);
    step();
    reset = 1'b0;
    step();
    chk("t6_ready", 32'(s_ready), 32'd1);
    stream(2, 0, 4096, 1'b1, -1, -1);
    chk("t6_pend_ready", 32'(s_ready), 32'd0);
    pulse_sfd();
    chk("t6_swap", 32'(disp_bank), 32'd1);
    read_table(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
